regfile_32x64: RTL and testbench

//  - 32-entry x 64-bit architectural register file (X0..X31) for the single-cycle/pipelined ARM datapath.
//  - Holds the storage array and write decode whose outputs feed the two 64-bit 32:1 read-port muxes.
//  - Read data goes to the ALU operand / store-data path. Writeback drives the single write port.
//  - X31 (XZR) is hardwired to zero.

---
 rtl/regfile_32x64_pkg.sv | 10 +
 rtl/regfile_32x64_parts.sv | 34 +++
 rtl/regfile_32x64.sv | 69 ++++++
 tb/tb_regfile_32x64.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/regfile_32x64_pkg.sv
// Shared CPU definitions used by the register file: address width, the
// hardwired-zero register index and the architectural word type.
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] XZR = 5'd31;

  typedef logic [63:0] word_t;

endpackage : cpu_pkg

// File: rtl/regfile_32x64_parts.sv
// Building blocks of the register file: the gated 5:32 write decoder and the
// 32:1 word mux that forms each read port.
module decoder5_32
  import cpu_pkg::*;
(
  input  logic                  en_i,
  input  logic [REG_ADDR_W-1:0] sel_i,
  output logic [31:0]           out_o
);

  // XZR has no storage, so its enable never rises even when selected.
  always_comb begin
    out_o = '0;
    if (en_i) begin
      out_o[sel_i] = 1'b1;
    end
    out_o[XZR] = 1'b0;
  end

endmodule : decoder5_32

module mux32_word
  import cpu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0]      data_i [32],
  input  logic [REG_ADDR_W-1:0] sel_i,
  output logic [WIDTH-1:0]      data_o
);

  assign data_o = data_i[sel_i];

endmodule : mux32_word

// File: rtl/regfile_32x64.sv
// 32 x 64-bit architectural register file: one write port, two combinational
// read ports, X31 reads as zero, optional write-through bypass.
module regfile_32x64
  import cpu_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int NREGS  = 32,
  parameter int BYPASS = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWrite,
  input  logic [REG_ADDR_W-1:0] WriteRegister,
  input  logic [WIDTH-1:0]      WriteData,
  input  logic [REG_ADDR_W-1:0] ReadRegister1,
  input  logic [REG_ADDR_W-1:0] ReadRegister2,
  output logic [WIDTH-1:0]      ReadData1,
  output logic [WIDTH-1:0]      ReadData2
);

  logic [NREGS-1:0] wr_en;
  logic [WIDTH-1:0] regs_q [NREGS-1];
  logic [WIDTH-1:0] mux_in [NREGS];
  logic [WIDTH-1:0] port1_data;
  logic [WIDTH-1:0] port2_data;
  logic             hit1;
  logic             hit2;

  decoder5_32 u_decoder (
    .en_i  (RegWrite),
    .sel_i (WriteRegister),
    .out_o (wr_en)
  );

  for (genvar g = 0; g < NREGS - 1; g++) begin : g_reg
    always_ff @(posedge clk) begin
      if (reset) begin
        regs_q[g] <= '0;
      end else if (wr_en[g]) begin
        regs_q[g] <= WriteData;
      end
    end
    assign mux_in[g] = regs_q[g];
  end

  assign mux_in[NREGS-1] = '0;

  mux32_word #(.WIDTH(WIDTH)) u_rd_mux1 (
    .data_i (mux_in),
    .sel_i  (ReadRegister1),
    .data_o (port1_data)
  );

  mux32_word #(.WIDTH(WIDTH)) u_rd_mux2 (
    .data_i (mux_in),
    .sel_i  (ReadRegister2),
    .data_o (port2_data)
  );

  // The decoded enable already excludes XZR and idle cycles, so it doubles as
  // the bypass match; a reset cycle drops the write and thus the bypass.
  always_comb begin
    hit1      = (BYPASS != 0) && !reset && wr_en[ReadRegister1];
    hit2      = (BYPASS != 0) && !reset && wr_en[ReadRegister2];
    ReadData1 = hit1 ? WriteData : port1_data;
    ReadData2 = hit2 ? WriteData : port2_data;
  end

endmodule : regfile_32x64

// File: tb/tb_regfile_32x64.sv
// Bench for regfile_32x64: a plain instance and a write-through instance share
// one stimulus stream; a negedge monitor checks both against queued values.
module tb_regfile_32x64;
  import cpu_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset     = 1'b0;
  logic       reg_write = 1'b0;
  logic [4:0] wr_reg    = '0;
  word_t      wr_data   = '0;
  logic [4:0] rd_reg1   = '0;
  logic [4:0] rd_reg2   = '0;
  word_t      rd_data1, rd_data2, byp_data1, byp_data2;

  regfile_32x64 #(.WIDTH(64), .NREGS(32), .BYPASS(0)) u_dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (reg_write),
    .WriteRegister (wr_reg),
    .WriteData     (wr_data),
    .ReadRegister1 (rd_reg1),
    .ReadRegister2 (rd_reg2),
    .ReadData1     (rd_data1),
    .ReadData2     (rd_data2)
  );

  regfile_32x64 #(.WIDTH(64), .NREGS(32), .BYPASS(1)) u_dut_byp (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (reg_write),
    .WriteRegister (wr_reg),
    .WriteData     (wr_data),
    .ReadRegister1 (rd_reg1),
    .ReadRegister2 (rd_reg2),
    .ReadData1     (byp_data1),
    .ReadData2     (byp_data2)
  );

  // scoreboard: four words per check (plain p1, p2, bypass p1, p2)
  logic [63:0] exp_q[$];
  int          tag_q[$];
  logic        chk_vld  = 1'b0;
  int          checks   = 0;
  int          failures = 0;

  task automatic compare(input int tag, input string name, input word_t got, input word_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL t%0d %s got=%h exp=%h", tag, name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_vld) begin
      if (tag_q.size() == 0 || exp_q.size() < 4) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_underflow got=empty exp=entry");
      end else begin
        int    tag;
        word_t e1, e2, b1, b2;
        tag = tag_q.pop_front();
        e1  = exp_q.pop_front();
        e2  = exp_q.pop_front();
        b1  = exp_q.pop_front();
        b2  = exp_q.pop_front();
        compare(tag, "rd1", rd_data1, e1);
        compare(tag, "rd2", rd_data2, e2);
        compare(tag, "byp_rd1", byp_data1, b1);
        compare(tag, "byp_rd2", byp_data2, b2);
      end
    end
  end

  // driver: one call = one clock cycle of inputs, optionally with expectations
  task automatic step(input logic rst, input logic we, input logic [4:0] wr,
                      input word_t wd, input logic [4:0] r1, input logic [4:0] r2,
                      input logic chk, input word_t e1, input word_t e2,
                      input word_t b1, input word_t b2, input int tag);
    @(posedge clk);
    #1;
    reset     = rst;
    reg_write = we;
    wr_reg    = wr;
    wr_data   = wd;
    rd_reg1   = r1;
    rd_reg2   = r2;
    if (chk) begin
      tag_q.push_back(tag);
      exp_q.push_back(e1);
      exp_q.push_back(e2);
      exp_q.push_back(b1);
      exp_q.push_back(b2);
    end
    chk_vld = chk;
  endtask

  initial begin
    // 1: reset, then every index on both ports reads zero
    step(1'b1, 1'b0, 5'd0, 64'h0, 5'd0, 5'd0, 1'b0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 1'b0, 5'd0, 64'h0, 5'(i), 5'(31 - i), 1'b1, 0, 0, 0, 0, 1);
    end

    // 2: write X0..X30 = A+i; bypass instance sees the new value in-cycle
    for (int i = 0; i < 31; i++) begin
      step(1'b0, 1'b1, 5'(i), 64'hA + 64'(i), 5'(i), 5'd31, 1'b1,
           64'h0, 64'h0, 64'hA + 64'(i), 64'h0, 2);
    end
    for (int i = 0; i < 31; i++) begin
      step(1'b0, 1'b0, 5'd0, 64'h0, 5'(i), 5'(30 - i), 1'b1,
           64'hA + 64'(i), 64'hA + 64'(30 - i), 64'hA + 64'(i), 64'hA + 64'(30 - i), 2);
    end

    // 3: write to XZR is discarded and never bypassed
    step(1'b0, 1'b1, 5'd31, 64'hDEAD_BEEF, 5'd31, 5'd31, 1'b1, 0, 0, 0, 0, 3);
    for (int i = 0; i < 31; i++) begin
      step(1'b0, 1'b0, 5'd0, 64'h0, 5'(i), 5'd31, 1'b1,
           64'hA + 64'(i), 64'h0, 64'hA + 64'(i), 64'h0, 3);
    end

    // 4: RegWrite=0 leaves X5 alone
    step(1'b0, 1'b0, 5'd5, 64'hFFFF, 5'd5, 5'd5, 1'b1, 64'hF, 64'hF, 64'hF, 64'hF, 4);
    step(1'b0, 1'b0, 5'd0, 64'h0, 5'd5, 5'd5, 1'b1, 64'hF, 64'hF, 64'hF, 64'hF, 4);

    // 5: read-during-write of X7
    step(1'b0, 1'b1, 5'd7, 64'h1234, 5'd7, 5'd8, 1'b1, 64'h11, 64'h12, 64'h1234, 64'h12, 5);
    step(1'b0, 1'b0, 5'd0, 64'h0, 5'd7, 5'd7, 1'b1, 64'h1234, 64'h1234, 64'h1234, 64'h1234, 5);

    // 6: reset beats a simultaneous write; the following write proceeds
    step(1'b1, 1'b1, 5'd3, 64'h55, 5'd3, 5'd3, 1'b1, 64'hD, 64'hD, 64'hD, 64'hD, 6);
    step(1'b0, 1'b1, 5'd3, 64'h66, 5'd3, 5'd7, 1'b1, 64'h0, 64'h0, 64'h66, 64'h0, 6);
    step(1'b0, 1'b0, 5'd0, 64'h0, 5'd3, 5'd3, 1'b1, 64'h66, 64'h66, 64'h66, 64'h66, 6);
    step(1'b0, 1'b0, 5'd0, 64'h0, 5'd7, 5'd31, 1'b1, 64'h0, 64'h0, 64'h0, 64'h0, 6);

    @(posedge clk);
    #1;
    chk_vld = 1'b0;
    @(posedge clk);
    checks++;
    if (tag_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", tag_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_regfile_32x64
